// File: rtl/uart_tx_mmio_if.sv
// Load/store bus slice between the CPU data-memory port and the memory-mapped UART.
interface uart_tx_mmio_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] rdata;
   logic        hit;

   modport master (output addr, wdata, wr_en, rd_en, input rdata, hit);
   modport slave  (input addr, wdata, wr_en, rd_en, output rdata, hit);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL window, byte FIFO and
// a serialiser FSM that chains frames back to back while bytes are queued.
module uart_tx_mmio #(
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_mmio_if.slave bus,
   output logic          tx,
   output logic          tx_busy
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [15:0]      BAUD_LAST = 16'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             enable;
   logic [7:0]       shift;
   logic [2:0]       bit_idx;
   logic [15:0]      baud_cnt;

   logic       hit;
   logic [1:0] offset;
   logic       full;
   logic       empty;
   logic       push_req;
   logic       push_ok;
   logic       pop;
   logic       ovf_set;
   logic       ovf_clr;
   logic       ctrl_wr;
   logic       bit_end;
   logic [31:0] rdata;
   logic       unused_bits;

   assign hit      = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign offset   = bus.addr[3:2];
   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);
   assign bit_end  = (baud_cnt == BAUD_LAST);

   // A pop happens from IDLE, or straight out of the last STOP cycle so frames abut.
   assign pop      = enable && !empty &&
                     ((state == IDLE) || ((state == STOP) && bit_end));
   assign push_req = bus.wr_en && hit && (offset == 2'd0);
   assign push_ok  = push_req && (!full || pop);
   assign ovf_set  = push_req && full && !pop;
   assign ovf_clr  = bus.wr_en && hit && (offset == 2'd1) && bus.wdata[3];
   assign ctrl_wr  = bus.wr_en && hit && (offset == 2'd2);

   assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:8]};

   always_comb begin
      rdata = '0;
      if (bus.rd_en && hit) begin
         case (offset)
            2'd1:    rdata = {16'd0, 8'(count), 4'd0, overflow, tx_busy, empty, full};
            2'd2:    rdata = {31'd0, enable};
            default: rdata = '0;
         endcase
      end
   end

   assign bus.rdata = rdata;
   assign bus.hit   = hit;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= bus.wdata[7:0];
      if (pop)     shift       <= mem[rd_ptr];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         enable   <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         // A new overflow outranks a clear landing on the same edge.
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
         if (ctrl_wr) enable <= bus.wdata[0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               if (pop) begin
                  state   <= START;
                  tx      <= 1'b0;
                  tx_busy <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  tx       <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shift[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     state <= START;
                     tx    <= 1'b0;
                  end else begin
                     state   <= IDLE;
                     tx_busy <= 1'b0;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: begin
               state   <= IDLE;
               tx      <= 1'b1;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end
endmodule
